// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the FSM encoding, alignment width and the op-error classification.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

  localparam int ALIGN_BITS = 3;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } mem_err_t;

  // Decides at accept time whether an op may reach the memory at all.
  function automatic mem_err_t classify_op(input logic                  rd,
                                           input logic                  wr,
                                           input logic [ALIGN_BITS-1:0] low_addr);
    if (rd && wr) return ERR_ILLEGAL;
    if ((rd || wr) && (low_addr != '0)) return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter used to bound the wait for a memory acknowledge.
// expired is high while the count sits at TIMEOUT-1.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access.sv
// Memory stage: runs one req/ack data-memory transaction per instruction, stalls
// upstream meanwhile, and retires load data plus the branch decision.
module memory_access
  import mem_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         MemRead_M,
  input  logic         MemWrite_M,
  input  logic         Branch_M,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         out_valid,
  output logic [N-1:0] readData_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out,
  output logic         mem_err
);

  mem_state_t   state_q, state_d;
  logic         dm_req_q, dm_req_d;
  logic         dm_we_q, dm_we_d;
  logic [N-1:0] dm_addr_q, dm_addr_d;
  logic [N-1:0] dm_wdata_q, dm_wdata_d;

  // Pending results of the instruction in flight; published on entry to RESP.
  logic         pcsrc_pend_q, pcsrc_pend_d;
  logic [N-1:0] target_pend_q, target_pend_d;
  logic [N-1:0] rdata_pend_q, rdata_pend_d;
  mem_err_t     err_pend_q, err_pend_d;

  logic [N-1:0] read_data_q, read_data_d;
  logic         pcsrc_q, pcsrc_d;
  logic [N-1:0] pcbranch_q, pcbranch_d;
  logic         mem_err_q, mem_err_d;

  mem_err_t     op_err;
  logic         expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != REQ),
    .enable  (dm_req_q),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    pcsrc_pend_d  = pcsrc_pend_q;
    target_pend_d = target_pend_q;
    rdata_pend_d  = rdata_pend_q;
    err_pend_d    = err_pend_q;
    read_data_d   = read_data_q;
    pcsrc_d       = pcsrc_q;
    pcbranch_d    = pcbranch_q;
    mem_err_d     = mem_err_q;
    op_err        = classify_op(MemRead_M, MemWrite_M, aluResult_M[ALIGN_BITS-1:0]);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dm_addr_d     = aluResult_M;
          dm_wdata_d    = writeData_M;
          dm_we_d       = MemWrite_M;
          pcsrc_pend_d  = Branch_M & zero_M;
          target_pend_d = PCBranch_M;
          rdata_pend_d  = '0;
          err_pend_d    = op_err;
          if ((MemRead_M || MemWrite_M) && (op_err == ERR_NONE)) begin
            state_d  = REQ;
            dm_req_d = 1'b1;
          end else begin
            state_d  = RESP;
          end
        end
      end
      REQ: begin
        // A REQ cycle with the request already dropped is the wind-down cycle.
        if (dm_req_q) begin
          if (dm_ack) begin
            dm_req_d = 1'b0;
            if (!dm_we_q) rdata_pend_d = dm_rdata;
          end else if (expired) begin
            dm_req_d   = 1'b0;
            err_pend_d = ERR_TIMEOUT;
          end
        end else begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q != RESP) && (state_d == RESP)) begin
      read_data_d = rdata_pend_d;
      pcsrc_d     = pcsrc_pend_d;
      pcbranch_d  = target_pend_d;
      mem_err_d   = (err_pend_d != ERR_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      pcsrc_pend_q  <= 1'b0;
      target_pend_q <= '0;
      rdata_pend_q  <= '0;
      err_pend_q    <= ERR_NONE;
      read_data_q   <= '0;
      pcsrc_q       <= 1'b0;
      pcbranch_q    <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      pcsrc_pend_q  <= pcsrc_pend_d;
      target_pend_q <= target_pend_d;
      rdata_pend_q  <= rdata_pend_d;
      err_pend_q    <= err_pend_d;
      read_data_q   <= read_data_d;
      pcsrc_q       <= pcsrc_d;
      pcbranch_q    <= pcbranch_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == RESP);
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign readData_M   = read_data_q;
  assign PCSrc_M      = pcsrc_q;
  assign PCBranch_out = pcbranch_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: a transaction-level model derives the cycle
// schedule and results of each instruction; a negedge process compares every cycle.
module tb_memory_access;

  localparam int N       = 64;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic         MemRead_M, MemWrite_M, Branch_M, zero_M;
  logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
  logic         dm_req, dm_we, dm_ack;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         out_valid, PCSrc_M, mem_err;
  logic [N-1:0] readData_M, PCBranch_out;

  always #5 clk = ~clk;

  memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .MemRead_M    (MemRead_M),
    .MemWrite_M   (MemWrite_M),
    .Branch_M     (Branch_M),
    .zero_M       (zero_M),
    .aluResult_M  (aluResult_M),
    .writeData_M  (writeData_M),
    .PCBranch_M   (PCBranch_M),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .out_valid    (out_valid),
    .readData_M   (readData_M),
    .PCSrc_M      (PCSrc_M),
    .PCBranch_out (PCBranch_out),
    .mem_err      (mem_err)
  );

  typedef struct {
    bit           rd, wr, br, zero;
    logic [N-1:0] addr, wdata, target, rdata;
    int           ack_cycle;  // REQ cycle (1-based) carrying dm_ack; 0 means never
  } txn_t;

  int checks = 0;
  int errors = 0;

  // Model state: per-cycle expectations and the last retired results.
  bit           chk_en = 1'b0;
  bit           exp_ready = 1'b1, exp_req = 1'b0, exp_valid = 1'b0, exp_we = 1'b0;
  logic [N-1:0] exp_addr = '0, exp_wdata = '0;
  logic [N-1:0] last_rd = '0, last_target = '0;
  bit           last_pcsrc = 1'b0, last_err = 1'b0;

  int cyc = -1;
  int act_out_cycle = -1;
  int act_req_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",     64'(in_ready),     64'(exp_ready));
      check("dm_req",       64'(dm_req),       64'(exp_req));
      check("out_valid",    64'(out_valid),    64'(exp_valid));
      check("readData_M",   readData_M,        last_rd);
      check("PCSrc_M",      64'(PCSrc_M),      64'(last_pcsrc));
      check("PCBranch_out", PCBranch_out,      last_target);
      check("mem_err",      64'(mem_err),      64'(last_err));
      if (exp_req) begin
        check("dm_we",    64'(dm_we), 64'(exp_we));
        check("dm_addr",  dm_addr,    exp_addr);
        check("dm_wdata", dm_wdata,   exp_wdata);
      end
      if (dm_req) act_req_cnt++;
      if (out_valid && act_out_cycle < 0) act_out_cycle = cyc;
    end
  end

  function automatic txn_t mk(input bit rd, input bit wr, input bit br, input bit zero,
                              input logic [N-1:0] addr, input logic [N-1:0] wdata,
                              input logic [N-1:0] target, input logic [N-1:0] rdata,
                              input int ack_cycle);
    txn_t t;
    t.rd = rd; t.wr = wr; t.br = br; t.zero = zero;
    t.addr = addr; t.wdata = wdata; t.target = target; t.rdata = rdata;
    t.ack_cycle = ack_cycle;
    return t;
  endfunction

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_garbage();
    in_valid    = 1'($urandom_range(0, 1));
    MemRead_M   = 1'($urandom_range(0, 1));
    MemWrite_M  = 1'($urandom_range(0, 1));
    Branch_M    = 1'($urandom_range(0, 1));
    zero_M      = 1'($urandom_range(0, 1));
    aluResult_M = rnd64();
    writeData_M = rnd64();
    PCBranch_M  = rnd64();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc = -1;
      drive_garbage();
      in_valid  = 1'b0;
      dm_ack    = 1'($urandom_range(0, 1));
      dm_rdata  = rnd64();
      exp_ready = 1'b1; exp_req = 1'b0; exp_valid = 1'b0;
    end
  endtask

  // Derives the whole schedule of one instruction from the stage's rules, then
  // plays it cycle by cycle while acting as the data memory.
  task automatic run_txn(input txn_t t, output int out_cyc, output int req_cnt);
    bit           is_mem, err, timed_out;
    int           req_len, out_cycle;
    logic [2:0]   low;
    logic [N-1:0] rd_res;
    low       = t.addr[2:0];
    is_mem    = t.rd || t.wr;
    err       = (t.rd && t.wr) || (is_mem && low != 3'd0);
    timed_out = is_mem && !err && !(t.ack_cycle >= 1 && t.ack_cycle <= TIMEOUT);
    if (!is_mem || err) begin
      req_len = 0; out_cycle = 1;
    end else begin
      req_len   = timed_out ? TIMEOUT : t.ack_cycle;
      out_cycle = req_len + 2;
    end
    rd_res = (t.rd && !err && !timed_out) ? t.rdata : '0;
    act_out_cycle = -1;
    act_req_cnt   = 0;
    for (int c = 0; c <= out_cycle; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (c == 0) begin
        in_valid = 1'b1; MemRead_M = t.rd; MemWrite_M = t.wr;
        Branch_M = t.br; zero_M = t.zero;
        aluResult_M = t.addr; writeData_M = t.wdata; PCBranch_M = t.target;
      end else begin
        drive_garbage();
      end
      if (c >= 1 && c <= req_len) dm_ack = (c == t.ack_cycle);
      else                        dm_ack = 1'($urandom_range(0, 1));
      dm_rdata  = (c == t.ack_cycle) ? t.rdata : rnd64();
      exp_ready = (c == 0);
      exp_req   = (c >= 1 && c <= req_len);
      exp_valid = (c == out_cycle);
      exp_we    = t.wr; exp_addr = t.addr; exp_wdata = t.wdata;
      if (c == out_cycle) begin
        last_rd = rd_res; last_pcsrc = t.br & t.zero;
        last_target = t.target; last_err = err || timed_out;
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    out_cyc  = act_out_cycle;
    req_cnt  = act_req_cnt;
  endtask

  initial begin
    int   oc, rc;
    txn_t t;
    reset = 1'b1;
    in_valid = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; Branch_M = 1'b0; zero_M = 1'b0;
    aluResult_M = '0; writeData_M = '0; PCBranch_M = '0; dm_ack = 1'b0; dm_rdata = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dm_we",    64'(dm_we), 64'd0);
    check("rst_dm_addr",  dm_addr,    64'd0);
    check("rst_dm_wdata", dm_wdata,   64'd0);
    #1 reset = 1'b0;
    idle(2);

    // Store, ack in the second REQ cycle.
    run_txn(mk(0, 1, 0, 0, 64'h40, 64'hDEAD_BEEF, 64'h0, 64'h0, 2), oc, rc);
    check("t1_latency", 64'(oc), 64'd4);
    check("t1_req_cycles", 64'(rc), 64'd2);
    check("t1_mem_err", 64'(mem_err), 64'd0);

    // Load, ack in the first REQ cycle.
    run_txn(mk(1, 0, 0, 0, 64'h08, 64'h0, 64'h0, 64'h1234, 1), oc, rc);
    check("t2_latency", 64'(oc), 64'd3);
    check("t2_rdata", readData_M, 64'h1234);

    // CBZ taken, no memory op.
    run_txn(mk(0, 0, 1, 1, 64'h0, 64'h0, 64'h100, 64'h0, 1), oc, rc);
    check("t3_latency", 64'(oc), 64'd1);
    check("t3_req_cycles", 64'(rc), 64'd0);
    check("t3_pcsrc", 64'(PCSrc_M), 64'd1);
    check("t3_target", PCBranch_out, 64'h100);

    // Misaligned load, then read+write together.
    run_txn(mk(1, 0, 0, 0, 64'h43, 64'h0, 64'h0, 64'h5555, 1), oc, rc);
    check("t4_req_cycles", 64'(rc), 64'd0);
    check("t4_mem_err", 64'(mem_err), 64'd1);
    check("t4_rdata", readData_M, 64'd0);
    run_txn(mk(1, 1, 0, 0, 64'h10, 64'h0, 64'h0, 64'h0, 1), oc, rc);
    check("t4b_mem_err", 64'(mem_err), 64'd1);

    // Load that never gets acknowledged.
    run_txn(mk(1, 0, 0, 0, 64'h18, 64'h0, 64'h0, 64'hABCD, 0), oc, rc);
    check("t5_req_cycles", 64'(rc), 64'd16);
    check("t5_latency", 64'(oc), 64'd18);
    check("t5_mem_err", 64'(mem_err), 64'd1);
    idle(1);

    // Ack on the last allowed cycle still succeeds.
    run_txn(mk(1, 0, 0, 0, 64'h20, 64'h0, 64'h0, 64'h77, TIMEOUT), oc, rc);
    check("ackwin_mem_err", 64'(mem_err), 64'd0);
    check("ackwin_rdata", readData_M, 64'h77);

    // Reset in the third REQ cycle: request drops, nothing retires.
    act_out_cycle = -1;
    act_req_cnt   = 0;
    t = mk(1, 0, 1, 1, 64'h28, 64'h0, 64'h300, 64'h0, 0);
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (c == 0) begin
        in_valid = 1'b1; MemRead_M = t.rd; MemWrite_M = t.wr; Branch_M = t.br; zero_M = t.zero;
        aluResult_M = t.addr; writeData_M = t.wdata; PCBranch_M = t.target;
      end else begin
        drive_garbage();
        if (c == 4) in_valid = 1'b0;
      end
      dm_ack = 1'b0;
      reset  = (c == 3);
      exp_ready = (c == 0 || c == 4);
      exp_req   = (c >= 1 && c <= 3);
      exp_valid = 1'b0;
      exp_we = t.wr; exp_addr = t.addr; exp_wdata = t.wdata;
      if (c == 4) begin
        last_rd = '0; last_pcsrc = 1'b0; last_target = '0; last_err = 1'b0;
      end
    end
    @(negedge clk); #1;
    check("t6_req_cycles", 64'(act_req_cnt), 64'd3);
    check("t6_no_out_valid", 64'(act_out_cycle), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_dm_addr_rst", dm_addr, 64'd0);
    run_txn(mk(1, 0, 0, 0, 64'h30, 64'h0, 64'h0, 64'hCAFE, 1), oc, rc);
    check("t6_next_latency", 64'(oc), 64'd3);
    check("t6_next_rdata", readData_M, 64'hCAFE);

    // Random instruction mix.
    for (int i = 0; i < 80; i++) begin
      logic [N-1:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      a = rnd64();
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      t = mk(sel <= 3 || sel == 9, (sel >= 4 && sel <= 6) || sel == 9,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             a, rnd64(), rnd64(), rnd64(), int'($urandom_range(0, TIMEOUT + 3)));
      run_txn(t, oc, rc);
      idle(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
